// File: rtl/memoria_pkg.sv
// memoria_pkg: shared definitions for the data-memory arbiter.
//   - default address/data widths of the 128 x 8 data memory
//   - FSM state encoding of the access sequencer
//   - requester port identifiers
package memoria_pkg;

  localparam int ANCHO_DIR_DEF  = 7;
  localparam int ANCHO_DATO_DEF = 8;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACCESO = 2'd1,
    PULSO  = 2'd2,
    FIN    = 2'd3
  } estado_t;

  localparam logic PUERTO_CPU = 1'b0;
  localparam logic PUERTO_ES  = 1'b1;

endpackage

// File: rtl/selector_rr.sv
// selector_rr: combinational two-way winner selection.
// Ports:
//   peticion0/1  in   pending requests from puerto 0 / puerto 1
//   ultimo       in   port served by the previous transaction
//   hay_peticion out  at least one request is pending
//   ganador      out  winning port (PUERTO_CPU / PUERTO_ES)
// With PRIORIDAD_FIJA != 0 puerto 0 wins ties; otherwise a tie goes to the
// port that was not served last.
module selector_rr
  import memoria_pkg::*;
#(
  parameter int PRIORIDAD_FIJA = 0
) (
  input  logic peticion0,
  input  logic peticion1,
  input  logic ultimo,
  output logic hay_peticion,
  output logic ganador
);

  always_comb begin
    hay_peticion = peticion0 | peticion1;
    ganador      = PUERTO_CPU;
    if (peticion0 && peticion1) begin
      ganador = (PRIORIDAD_FIJA != 0) ? PUERTO_CPU : ~ultimo;
    end else if (peticion1) begin
      ganador = PUERTO_ES;
    end
  end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: two-requester controller in front of memoriaDatos.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   peticion0/1, escribir0/1, direccion0/1, dato_entrada0/1
//                           request side of puerto 0 (CPU) and puerto 1 (E/S)
//   concedido0/1, listo0/1  one-cycle grant / completion pulses
//   dato_salida             last read data, held until the next read completes
//   guardar, activa, direccionMemoria, entradaDatos
//                           memory strobe, enable, address and write data
//   salidaDatos             combinational memory read data
//   estado                  current sequencer state (debug)
//
// Handshake: a requester raises peticion with stable operands and holds them
// until it sees concedido; operands are latched at grant, so they may change
// afterwards. listo marks completion; a peticion still high the next time
// REPOSO samples is taken as a new transaction.
//
// Sequence: REPOSO (sample, grant) -> ACCESO -> [PULSO, writes only] -> FIN.
// Address and data are registered one full cycle before guardar rises, and
// guardar is high for exactly the PULSO cycle.
module arbitro_memoria_datos
  import memoria_pkg::*;
#(
  parameter int ANCHO_DIR      = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO     = ANCHO_DATO_DEF,
  parameter int PRIORIDAD_FIJA = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  peticion0,
  input  logic                  peticion1,
  input  logic                  escribir0,
  input  logic                  escribir1,
  input  logic [ANCHO_DIR-1:0]  direccion0,
  input  logic [ANCHO_DIR-1:0]  direccion1,
  input  logic [ANCHO_DATO-1:0] dato_entrada0,
  input  logic [ANCHO_DATO-1:0] dato_entrada1,
  output logic                  concedido0,
  output logic                  concedido1,
  output logic                  listo0,
  output logic                  listo1,
  output logic [ANCHO_DATO-1:0] dato_salida,
  output logic                  guardar,
  output logic                  activa,
  output logic [ANCHO_DIR-1:0]  direccionMemoria,
  output logic [ANCHO_DATO-1:0] entradaDatos,
  input  logic [ANCHO_DATO-1:0] salidaDatos,
  output logic [1:0]            estado
);

  estado_t               estado_q, estado_d;
  logic                  ultimo_q, ultimo_d;
  logic                  ganador_q, ganador_d;
  logic                  escritura_q, escritura_d;
  logic                  guardar_d, activa_d;
  logic                  concedido0_d, concedido1_d, listo0_d, listo1_d;
  logic [ANCHO_DIR-1:0]  direccion_d;
  logic [ANCHO_DATO-1:0] entrada_d, salida_d;
  logic                  hay_peticion, ganador_sel;

  selector_rr #(
    .PRIORIDAD_FIJA(PRIORIDAD_FIJA)
  ) u_selector (
    .peticion0   (peticion0),
    .peticion1   (peticion1),
    .ultimo      (ultimo_q),
    .hay_peticion(hay_peticion),
    .ganador     (ganador_sel)
  );

  always_comb begin
    estado_d     = estado_q;
    ultimo_d     = ultimo_q;
    ganador_d    = ganador_q;
    escritura_d  = escritura_q;
    direccion_d  = direccionMemoria;
    entrada_d    = entradaDatos;
    salida_d     = dato_salida;
    activa_d     = activa;
    guardar_d    = 1'b0;
    concedido0_d = 1'b0;
    concedido1_d = 1'b0;
    listo0_d     = 1'b0;
    listo1_d     = 1'b0;

    case (estado_q)
      REPOSO: begin
        activa_d = 1'b0;
        if (hay_peticion) begin
          estado_d  = ACCESO;
          ganador_d = ganador_sel;
          activa_d  = 1'b1;
          if (ganador_sel == PUERTO_ES) begin
            escritura_d  = escribir1;
            direccion_d  = direccion1;
            entrada_d    = dato_entrada1;
            concedido1_d = 1'b1;
          end else begin
            escritura_d  = escribir0;
            direccion_d  = direccion0;
            entrada_d    = dato_entrada0;
            concedido0_d = 1'b1;
          end
        end
      end

      ACCESO: begin
        if (escritura_q) begin
          // Operands have been stable for this whole cycle; strobe next.
          estado_d  = PULSO;
          guardar_d = 1'b1;
        end else begin
          estado_d = FIN;
          salida_d = salidaDatos;
          activa_d = 1'b0;
          ultimo_d = ganador_q;
          listo0_d = (ganador_q == PUERTO_CPU);
          listo1_d = (ganador_q == PUERTO_ES);
        end
      end

      PULSO: begin
        estado_d = FIN;
        activa_d = 1'b0;
        ultimo_d = ganador_q;
        listo0_d = (ganador_q == PUERTO_CPU);
        listo1_d = (ganador_q == PUERTO_ES);
      end

      FIN: begin
        estado_d = REPOSO;
      end

      default: begin
        estado_d = REPOSO;
        activa_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q         <= REPOSO;
      ultimo_q         <= PUERTO_ES;
      ganador_q        <= PUERTO_CPU;
      escritura_q      <= 1'b0;
      guardar          <= 1'b0;
      activa           <= 1'b0;
      direccionMemoria <= '0;
      entradaDatos     <= '0;
      dato_salida      <= '0;
      concedido0       <= 1'b0;
      concedido1       <= 1'b0;
      listo0           <= 1'b0;
      listo1           <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      ultimo_q         <= ultimo_d;
      ganador_q        <= ganador_d;
      escritura_q      <= escritura_d;
      guardar          <= guardar_d;
      activa           <= activa_d;
      direccionMemoria <= direccion_d;
      entradaDatos     <= entrada_d;
      dato_salida      <= salida_d;
      concedido0       <= concedido0_d;
      concedido1       <= concedido1_d;
      listo0           <= listo0_d;
      listo1           <= listo1_d;
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: behavioural 128 x 8 memory, a transaction
// model that orders requests by the arbitration rules, an expected queue and
// a monitor that checks each grant/completion against it.
module tb_arbitro_memoria_datos;

  localparam int AD = 7;
  localparam int DW = 8;
  localparam int W  = 25;  // {port, wr, addr[6:0], wdata[7:0], rdata[7:0]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (round-robin) ----------------
  logic          peticion0 = 1'b0, peticion1 = 1'b0;
  logic          escribir0 = 1'b0, escribir1 = 1'b0;
  logic [AD-1:0] direccion0 = '0, direccion1 = '0;
  logic [DW-1:0] dato_entrada0 = '0, dato_entrada1 = '0;
  logic          concedido0, concedido1, listo0, listo1, guardar, activa;
  logic [DW-1:0] dato_salida, entradaDatos, salidaDatos;
  logic [AD-1:0] direccionMemoria;
  logic [1:0]    estado;

  arbitro_memoria_datos #(.ANCHO_DIR(AD), .ANCHO_DATO(DW), .PRIORIDAD_FIJA(0)) dut (
    .clk(clk), .reset(reset),
    .peticion0(peticion0), .peticion1(peticion1),
    .escribir0(escribir0), .escribir1(escribir1),
    .direccion0(direccion0), .direccion1(direccion1),
    .dato_entrada0(dato_entrada0), .dato_entrada1(dato_entrada1),
    .concedido0(concedido0), .concedido1(concedido1),
    .listo0(listo0), .listo1(listo1),
    .dato_salida(dato_salida), .guardar(guardar), .activa(activa),
    .direccionMemoria(direccionMemoria), .entradaDatos(entradaDatos),
    .salidaDatos(salidaDatos), .estado(estado)
  );

  // ---------------- second DUT (fixed priority) ----------------
  logic          pf0 = 1'b0, pf1 = 1'b0;
  logic          cf0, cf1, lf0, lf1, gf, af;
  logic [DW-1:0] dsf, edf, sdf;
  logic [AD-1:0] dmf;
  logic [1:0]    ef;

  arbitro_memoria_datos #(.ANCHO_DIR(AD), .ANCHO_DATO(DW), .PRIORIDAD_FIJA(1)) dut_f (
    .clk(clk), .reset(reset),
    .peticion0(pf0), .peticion1(pf1),
    .escribir0(escribir0), .escribir1(escribir1),
    .direccion0(direccion0), .direccion1(direccion1),
    .dato_entrada0(dato_entrada0), .dato_entrada1(dato_entrada1),
    .concedido0(cf0), .concedido1(cf1),
    .listo0(lf0), .listo1(lf1),
    .dato_salida(dsf), .guardar(gf), .activa(af),
    .direccionMemoria(dmf), .entradaDatos(edf),
    .salidaDatos(sdf), .estado(ef)
  );

  // ---------------- behavioural memories ----------------
  logic [DW-1:0] mem     [128];
  logic [DW-1:0] mem_f   [128];
  logic [DW-1:0] ref_mem [128];

  assign salidaDatos = mem[direccionMemoria];
  assign sdf         = mem_f[dmf];
  always @(posedge guardar) if (activa) mem[direccionMemoria] = entradaDatos;
  always @(posedge gf)      if (af)     mem_f[dmf]            = edf;

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  exp_q[$];
  logic [15:0]   q0[$], q1[$];      // per-port transactions {wr, addr, wdata}
  bit            rr_last = 1'b1;    // port served last; puerto 0 wins first
  bit            round_first = 1'b1;
  bit            scr_fixed = 1'b0;
  logic [AD-1:0] scr_addr = '0;
  logic [DW-1:0] scr_data = '0;

  // Both ports request simultaneously and keep requesting until their lists
  // are drained; while both have work the service alternates, otherwise the
  // single pending port is served.
  task automatic model_round();
    int          i0, i1;
    bit          w;
    logic [15:0] t;
    logic [DW-1:0] rd;
    i0 = 0;
    i1 = 0;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) w = ~rr_last;
      else w = (i0 < q0.size()) ? 1'b0 : 1'b1;
      if (w) begin t = q1[i1]; i1++; end
      else   begin t = q0[i0]; i0++; end
      rd = ref_mem[t[14:8]];
      if (t[15]) ref_mem[t[14:8]] = t[7:0];
      exp_q.push_back({w, t, rd});
      rr_last = w;
    end
  endtask

  function automatic logic [15:0] rand_txn(input bit narrow);
    logic [6:0] a;
    a = narrow ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
    return {1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic present(input bit p, input logic [15:0] t);
    if (!p) begin
      escribir0 = t[15]; direccion0 = t[14:8]; dato_entrada0 = t[7:0];
    end else begin
      escribir1 = t[15]; direccion1 = t[14:8]; dato_entrada1 = t[7:0];
    end
  endtask

  // Operands after the last grant are don't-care for the arbiter.
  task automatic scramble(input bit p);
    if (scr_fixed) present(p, {1'b1, scr_addr, scr_data});
    else           present(p, rand_txn(1'b0));
  endtask

  task automatic run_round();
    int n0, n1, g0, g1, l0, l1, cyc, first;
    n0 = q0.size(); n1 = q1.size();
    g0 = 0; g1 = 0; l0 = 0; l1 = 0;
    model_round();
    @(negedge clk);
    if (n0 > 0) present(1'b0, q0[0]);
    if (n1 > 0) present(1'b1, q1[0]);
    round_first = 1'b1;
    peticion0 = (n0 > 0);
    peticion1 = (n1 > 0);
    cyc = 0;
    first = -1;
    while ((l0 < n0 || l1 < n1) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if ((concedido0 || concedido1) && first < 0) first = cyc;
      if (concedido0) begin
        g0++;
        if (g0 < n0) present(1'b0, q0[g0]); else scramble(1'b0);
      end
      if (concedido1) begin
        g1++;
        if (g1 < n1) present(1'b1, q1[g1]); else scramble(1'b1);
      end
      if (listo0) begin l0++; if (l0 >= n0) peticion0 = 1'b0; end
      if (listo1) begin l1++; if (l1 >= n1) peticion1 = 1'b0; end
    end
    if (l0 < n0 || l1 < n1) begin
      fail("round_timeout");
      exp_q.delete();
    end
    chk("first_grant_latency", 32'(first), 32'd1);
    peticion0 = 1'b0;
    peticion1 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_strobes"}, 32'({guardar, activa, concedido0, concedido1, listo0, listo1}), 32'd0);
    chk({tag, "_dir"},     32'(direccionMemoria), 32'd0);
    chk({tag, "_din"},     32'(entradaDatos), 32'd0);
    chk({tag, "_dout"},    32'(dato_salida), 32'd0);
    chk({tag, "_estado"},  32'(estado), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0]  cur = '0;
  bit            in_flight = 1'b0;
  int            m_cyc = 0, n_g = 0, g_at = 0, cyc_now = 0, prev_grant = 0;
  bit            prev_wr = 1'b0;
  logic [DW-1:0] last_read = '0;
  bit            grant_log[$];

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      in_flight = 1'b0;
      last_read = '0;
    end else begin
      cyc_now++;
      if (concedido0 || concedido1) begin
        chk("grant_single", 32'(concedido0 & concedido1), 32'd0);
        chk("grant_while_busy", 32'(in_flight), 32'd0);
        if (exp_q.size() == 0) begin
          fail("unexpected_grant");
          in_flight = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          chk("grant_port",    32'(concedido1), 32'(cur[24]));
          chk("grant_addr",    32'(direccionMemoria), 32'(cur[22:16]));
          chk("grant_wdata",   32'(entradaDatos), 32'(cur[15:8]));
          chk("grant_activa",  32'(activa), 32'd1);
          chk("grant_guardar", 32'(guardar), 32'd0);
          if (!round_first) chk("grant_spacing", 32'(cyc_now - prev_grant), prev_wr ? 32'd4 : 32'd3);
          round_first = 1'b0;
          prev_grant = cyc_now;
          prev_wr = cur[23];
          grant_log.push_back(concedido1);
          in_flight = 1'b1;
          m_cyc = 0;
          n_g = 0;
          g_at = 0;
        end
      end else if (in_flight) begin
        m_cyc++;
        if (guardar) begin n_g++; g_at = m_cyc; end
        if (listo0 || listo1) begin
          chk("listo_single", 32'(listo0 & listo1), 32'd0);
          chk("listo_port",   32'(listo1), 32'(cur[24]));
          chk("latency",      32'(m_cyc), cur[23] ? 32'd2 : 32'd1);
          chk("strobe_count", 32'(n_g), cur[23] ? 32'd1 : 32'd0);
          if (cur[23]) chk("strobe_cycle", 32'(g_at), 32'd1);
          if (!cur[23]) last_read = cur[7:0];
          chk("dato_salida",  32'(dato_salida), 32'(last_read));
          chk("fin_idle",     32'({activa, guardar}), 32'd0);
          in_flight = 1'b0;
        end else if (m_cyc > 3) begin
          fail("listo_timeout");
          in_flight = 1'b0;
        end
      end else begin
        chk("idle_outputs", 32'({guardar, activa, listo0, listo1}), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  g0, g1, cyc, n0, n1;
    bit  rr_exp[4];
    rr_exp[0] = 1'b0; rr_exp[1] = 1'b1; rr_exp[2] = 1'b0; rr_exp[3] = 1'b1;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[7'h05] = 8'h3C;
    mem[7'h40] = 8'h9A;
    mem[7'h02] = 8'h00;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = mem[i];
      mem_f[i]   = mem[i];
    end

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Round-robin: both ports request continuously, two reads each.
    q0.delete(); q1.delete();
    q0.push_back({1'b0, 7'h10, 8'h00}); q0.push_back({1'b0, 7'h10, 8'h00});
    q1.push_back({1'b0, 7'h20, 8'h00}); q1.push_back({1'b0, 7'h20, 8'h00});
    grant_log.delete();
    run_round();
    chk("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", 32'(grant_log[i]), 32'(rr_exp[i]));

    // Single read of 0x05 by puerto 0.
    q0.delete(); q1.delete();
    q0.push_back({1'b0, 7'h05, 8'h00});
    run_round();
    chk("read_05", 32'(dato_salida), 32'h3C);

    // Single write by puerto 1, then read back by puerto 0.
    q0.delete(); q1.delete();
    q1.push_back({1'b1, 7'h7F, 8'hA7});
    run_round();
    chk("mem_7f", 32'(mem[7'h7F]), 32'hA7);
    q0.delete(); q1.delete();
    q0.push_back({1'b0, 7'h7F, 8'h00});
    run_round();
    chk("readback_7f", 32'(dato_salida), 32'hA7);

    // Operands change right after the grant of a write.
    q0.delete(); q1.delete();
    q0.push_back({1'b1, 7'h02, 8'h11});
    scr_fixed = 1'b1; scr_addr = 7'h03; scr_data = 8'hFF;
    run_round();
    scr_fixed = 1'b0;
    chk("latched_mem_02", 32'(mem[7'h02]), 32'h11);
    chk("latched_mem_03", 32'(mem[7'h03]), 32'(ref_mem[7'h03]));

    // Fixed priority: puerto 0 holds its request, puerto 1 never wins.
    @(negedge clk);
    escribir0 = 1'b0; escribir1 = 1'b0;
    direccion0 = 7'h10; direccion1 = 7'h20;
    pf0 = 1'b1; pf1 = 1'b1;
    g0 = 0; g1 = 0;
    repeat (24) begin
      @(negedge clk);
      if (cf0) g0++;
      if (cf1) g1++;
    end
    chk("fixed_p1_grants", 32'(g1), 32'd0);
    chk("fixed_p0_grants", 32'(g0), 32'd8);
    pf0 = 1'b0;
    cyc = 0;
    while (!cf1 && cyc < 8) begin @(negedge clk); cyc++; end
    chk("fixed_p1_served", 32'(cf1), 32'd1);
    chk("fixed_p1_latency", 32'(cyc), 32'd1);
    pf1 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ACCESO of a write of 0x55 to 0x40.
    @(negedge clk);
    escribir0 = 1'b1; direccion0 = 7'h40; dato_entrada0 = 8'h55;
    exp_q.push_back({1'b0, 1'b1, 7'h40, 8'h55, 8'h00});
    round_first = 1'b1;
    peticion0 = 1'b1;
    cyc = 0;
    while (!concedido0 && cyc < 10) begin @(negedge clk); cyc++; end
    chk("abort_grant_seen", 32'(concedido0), 32'd1);
    #2;
    reset = 1'b1;
    peticion0 = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    #2;
    reset = 1'b0;
    rr_last = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_mem_40", 32'(mem[7'h40]), 32'h9A);
    q0.delete(); q1.delete();
    q0.push_back({1'b0, 7'h40, 8'h00});
    run_round();
    chk("abort_readback_40", 32'(dato_salida), 32'h9A);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      q0.delete(); q1.delete();
      for (int i = 0; i < n0; i++) q0.push_back(rand_txn(r % 2 == 0));
      for (int i = 0; i < n1; i++) q1.push_back(rand_txn(r % 2 == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_round();
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 128; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
